// File: rtl/issue_scoreboard.sv
// Single-entry issue buffer with a 32-entry register write scoreboard.
// Holds one decoded instruction and stalls it while any of its registers has a write in flight.
module issue_scoreboard #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_dec_valid,
  output logic             o_dec_ready,
  input  logic [6:0]       i_dec_opcode,
  input  logic [6:0]       i_dec_funct7,
  input  logic [2:0]       i_dec_funct3,
  input  logic [XLEN-1:0]  i_dec_imm,
  input  logic [4:0]       i_dec_rs2,
  input  logic [4:0]       i_dec_rs1,
  input  logic [4:0]       i_dec_rd,
  output logic             o_iss_valid,
  input  logic             i_iss_ready,
  output logic [6:0]       o_iss_opcode,
  output logic [6:0]       o_iss_funct7,
  output logic [2:0]       o_iss_funct3,
  output logic [XLEN-1:0]  o_iss_imm,
  output logic [4:0]       o_iss_rs2,
  output logic [4:0]       o_iss_rs1,
  output logic [4:0]       o_iss_rd,
  input  logic             i_wb_valid,
  input  logic [4:0]       i_wb_rd,
  input  logic             i_flush,
  output logic [31:0]      o_pending,
  output logic             o_stall,
  output logic [CNT_W-1:0] o_stall_cnt
);

  // Handshakes: a transfer happens on a cycle where valid and ready are both high
  // at the rising edge; valid never depends on ready of the same interface.
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [6:0]       r_opcode;
  logic [6:0]       r_funct7;
  logic [2:0]       r_funct3;
  logic [XLEN-1:0]  r_imm;
  logic [4:0]       r_rs2;
  logic [4:0]       r_rs1;
  logic [4:0]       r_rd;
  logic [31:0]      r_pending;
  logic [31:0]      w_pending_nxt;
  logic [CNT_W-1:0] r_stall_cnt;

  logic w_full;
  logic w_hazard;
  logic w_iss_fire;
  logic w_dec_fire;

  assign w_full = (r_state == FULL);

  // Hazard looks only at registered state; a same-cycle writeback does not bypass.
  assign w_hazard = ((r_rs1 != 5'd0) & r_pending[r_rs1]) |
                    ((r_rs2 != 5'd0) & r_pending[r_rs2]) |
                    ((r_rd  != 5'd0) & r_pending[r_rd]);

  assign o_iss_valid = ~rst & w_full & ~w_hazard & ~i_flush;
  assign o_stall     = ~rst & w_full &  w_hazard & ~i_flush;
  assign w_iss_fire  = o_iss_valid & i_iss_ready;
  assign o_dec_ready = ~rst & ~i_flush & (~w_full | w_iss_fire);
  assign w_dec_fire  = i_dec_valid & o_dec_ready;

  always_comb begin
    w_state_nxt = r_state;
    if (i_flush) begin
      w_state_nxt = EMPTY;
    end else if (w_dec_fire) begin
      w_state_nxt = FULL;
    end else if (w_iss_fire) begin
      w_state_nxt = EMPTY;
    end
  end

  // Set is applied after clear so an issue to the same register wins.
  always_comb begin
    w_pending_nxt = r_pending;
    if (i_wb_valid && (i_wb_rd != 5'd0)) begin
      w_pending_nxt[i_wb_rd] = 1'b0;
    end
    if (w_iss_fire && (r_rd != 5'd0)) begin
      w_pending_nxt[r_rd] = 1'b1;
    end
    w_pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_opcode <= '0;
      r_funct7 <= '0;
      r_funct3 <= '0;
      r_imm    <= '0;
      r_rs2    <= '0;
      r_rs1    <= '0;
      r_rd     <= '0;
    end else if (w_dec_fire) begin
      r_opcode <= i_dec_opcode;
      r_funct7 <= i_dec_funct7;
      r_funct3 <= i_dec_funct3;
      r_imm    <= i_dec_imm;
      r_rs2    <= i_dec_rs2;
      r_rs1    <= i_dec_rs1;
      r_rd     <= i_dec_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending   <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_pending <= w_pending_nxt;
      if (o_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end
  end

  // A writeback to a register with no outstanding write points at an upstream bug.
  always_ff @(posedge clk) begin
    if (!rst && i_wb_valid && (i_wb_rd != 5'd0)) begin
      assert (r_pending[i_wb_rd])
        else $error("writeback to non-pending register x%0d", i_wb_rd);
    end
  end

  assign o_iss_opcode = r_opcode;
  assign o_iss_funct7 = r_funct7;
  assign o_iss_funct3 = r_funct3;
  assign o_iss_imm    = r_imm;
  assign o_iss_rs2    = r_rs2;
  assign o_iss_rs1    = r_rs1;
  assign o_iss_rd     = r_rd;
  assign o_pending    = r_pending;
  assign o_stall_cnt  = r_stall_cnt;

endmodule

// File: doc/issue_scoreboard.md
Name: issue_scoreboard

Overview:
- Issue controller between the instruction decoder output and the register-file/execute stage.
- Holds one decoded instruction in a single-entry buffer.
- Tracks outstanding register writes in a 32-bit scoreboard and stalls issue on RAW/WAW hazards until writeback clears them.
- Sequences the decoder's valid/ready stream and provides stall statistics.

Parameters:
XLEN, 32, data/immediate width
CNT_W, 16, width of saturating stall-cycle counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
i_dec_valid  in  1  decoded instruction valid
o_dec_ready  out  1  buffer can accept
i_dec_opcode  in  7  opcode
i_dec_funct7  in  7  funct7
i_dec_funct3  in  3  funct3
i_dec_imm  in  XLEN  immediate
i_dec_rs2  in  5  source 2 (0 when unused)
i_dec_rs1  in  5  source 1 (0 when unused)
i_dec_rd  in  5  destination (0 when none)
o_iss_valid  out  1  issue valid
i_iss_ready  in  1  execute stage accepts
o_iss_opcode/o_iss_funct7/o_iss_funct3/o_iss_imm/o_iss_rs2/o_iss_rs1/o_iss_rd  out  7/7/3/XLEN/5/5/5  buffered fields
i_wb_valid  in  1  writeback retiring
i_wb_rd  in  5  writeback destination
i_flush  in  1  discard buffered instruction
o_pending  out  32  scoreboard, bit n = write to xn outstanding
o_stall  out  1  buffer full and hazard present
o_stall_cnt  out  CNT_W  stall cycles, saturating

Behaviour:
- Reset (rst=1 at clock edge): state EMPTY, buffer fields 0, o_pending=0, o_stall_cnt=0.
  - While held in reset: o_iss_valid=0, o_stall=0, o_dec_ready=0.
  - Reset mid-stall discards everything.
- FSM, two states:
  - EMPTY: buffer invalid.
  - FULL: buffer holds one instruction.
- Handshakes:
  - dec_fire = i_dec_valid & o_dec_ready.
  - iss_fire = o_iss_valid & i_iss_ready.
- Hazard (combinational, from registered o_pending and buffer fields only; no same-cycle writeback bypass):
  - hazard = (rs1!=0 & pending[rs1]) | (rs2!=0 & pending[rs2]) | (rd!=0 & pending[rd]).
- o_iss_valid = FULL & ~hazard & ~i_flush.
- o_dec_ready = ~rst & ~i_flush & (EMPTY | iss_fire).
  - Allows back-to-back throughput of 1 instruction/cycle.
- Transitions:
  - EMPTY→FULL on dec_fire.
  - FULL→FULL on iss_fire & dec_fire (buffer reloaded).
  - FULL→EMPTY on iss_fire & ~dec_fire, or on i_flush.
- Latency: instruction accepted at edge N is presented on o_iss_* from cycle N+1 at the earliest.
- Buffer fields are stable while FULL and not fired; no field changes under backpressure.
- Scoreboard, each edge:
  - pending[i_wb_rd] cleared if i_wb_valid & i_wb_rd!=0.
  - pending[o_iss_rd] set if iss_fire & o_iss_rd!=0.
  - WAW stalling guarantees set and clear never target the same bit in one cycle; if they do, set wins.
  - Bit 0 is always 0.
- Writeback timing: writeback to a non-pending register has no effect (simulation $error).
  - Writeback clears take effect the following cycle, so a stalled consumer issues one cycle after its wb cycle.
- Flush:
  - Buffered instruction discarded; nothing issued; no new accept that cycle.
  - o_pending untouched, because in-flight writes still retire.
  - Writeback is still processed during flush.
- o_stall = FULL & hazard & ~i_flush.
  - o_stall_cnt increments each cycle o_stall=1 and saturates at all-ones.
  - Backpressure cycles (no hazard, i_iss_ready=0) are not counted.

Test Plan:
- Independent ops: rd=3 (rs 1,2), then rd=5 (rs 4,6), i_iss_ready=1 → issued cycles N+1, N+2; o_pending=0x28; o_stall_cnt=0.
- RAW: issue rd=3, then rs1=3; wb rd=3 held off 5 cycles → o_iss_valid=0 and o_stall=1 for those cycles plus 1; o_stall_cnt=6; issues cycle after wb; o_pending bit3 clear then set only if new rd=3.
- WAW: pending x7, instruction rd=7 with rs1=rs2=0 → stalled until wb rd=7; issues one cycle later; bit7 re-set.
- Backpressure: FULL, no hazard, i_iss_ready=0 for 4 cycles → o_iss_* stable, o_dec_ready=0, o_pending unchanged, o_stall_cnt unchanged; fires on 5th cycle.
- Flush during stall: rs1=3 stalled, i_flush=1 one cycle → EMPTY, no issue, o_pending bit3 stays 1; next i_dec_valid accepted the following cycle.
- x0 and reset cases:
  - rd=0 issue → o_pending=0.
  - rs1=0 never stalls.
  - wb rd=0 ignored.
  - rst=1 mid-stall → o_pending=0, EMPTY, o_stall_cnt=0 next cycle.
